// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - handshake/payload bundle for one pipeline stage register
interface pipe_stage_reg_if #(
  parameter int NB_REG  = 32,
  parameter int N_WORDS = 2,
  parameter int NB_CNT  = 16
);
  logic                        i_dunit_clk_en;
  logic                        i_valid;
  logic [NB_REG*N_WORDS-1:0]   i_data;
  logic                        i_flush;
  logic                        i_write;
  logic                        i_cnt_clear;
  logic [NB_REG*N_WORDS-1:0]   o_data;
  logic                        o_valid;
  logic                        o_bubble;
  logic [NB_CNT-1:0]           o_stall_cnt;
  logic [NB_CNT-1:0]           o_flush_cnt;

  // Upstream/control side: drives the request, observes the stage.
  modport master (
    output i_dunit_clk_en, i_valid, i_data, i_flush, i_write, i_cnt_clear,
    input  o_data, o_valid, o_bubble, o_stall_cnt, o_flush_cnt
  );

  // Stage side: consumes the request, presents registered state.
  modport slave (
    input  i_dunit_clk_en, i_valid, i_data, i_flush, i_write, i_cnt_clear,
    output o_data, o_valid, o_bubble, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with flush bubbles, stall hold and perf counters
module pipe_stage_reg #(
  parameter int NB_REG       = 32,
  parameter int N_WORDS      = 2,
  parameter int NB_CNT       = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  pipe_stage_reg_if.slave  bus
);
  localparam int              NB_DATA  = NB_REG * N_WORDS;
  localparam logic [3:0]      BUB_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};

  logic [NB_DATA-1:0] data_q;
  logic               valid_q;
  logic [3:0]         bub_cnt;
  logic [NB_CNT-1:0]  stall_cnt_q;
  logic [NB_CNT-1:0]  flush_cnt_q;

  logic en;
  logic in_bubble;
  logic hold;

  assign en        = bus.i_dunit_clk_en;
  assign in_bubble = (bub_cnt != 4'd0);
  // A stall is an edge where nothing else claims the stage and the write enable is low.
  assign hold      = !bus.i_flush && !in_bubble && !bus.i_write;

  // Payload and bubble sequencing: flush beats bubble beats write beats hold.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      bub_cnt <= 4'd0;
    end else if (en) begin
      if (bus.i_flush) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        bub_cnt <= BUB_LOAD;
      end else if (in_bubble) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        bub_cnt <= bub_cnt - 4'd1;
      end else if (bus.i_write) begin
        data_q  <= bus.i_data;
        valid_q <= bus.i_valid;
      end
    end
  end

  // Saturating performance counters; a clear wins over a same-edge increment.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (en) begin
      if (bus.i_cnt_clear) begin
        stall_cnt_q <= '0;
        flush_cnt_q <= '0;
      end else begin
        if (hold && valid_q && (stall_cnt_q != CNT_MAX)) begin
          stall_cnt_q <= stall_cnt_q + 1'b1;
        end
        if (bus.i_flush && (flush_cnt_q != CNT_MAX)) begin
          flush_cnt_q <= flush_cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_bubble    = in_bubble;
  assign bus.o_stall_cnt = stall_cnt_q;
  assign bus.o_flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg (three parameterisations, shared stimulus)
module tb_pipe_stage_reg;
  logic        clk;
  logic        rst;
  logic        en;
  logic        valid;
  logic [63:0] data;
  logic        flush;
  logic        write;
  logic        clr;

  int n_checks;
  int n_errors;

  // a: FLUSH_CYCLES=3, b: NB_CNT=2, c: FLUSH_CYCLES=4
  pipe_stage_reg_if #(.NB_REG(32), .N_WORDS(2), .NB_CNT(16)) if_a ();
  pipe_stage_reg_if #(.NB_REG(32), .N_WORDS(2), .NB_CNT(2))  if_b ();
  pipe_stage_reg_if #(.NB_REG(32), .N_WORDS(2), .NB_CNT(16)) if_c ();

  pipe_stage_reg #(.NB_REG(32), .N_WORDS(2), .NB_CNT(16), .FLUSH_CYCLES(3))
    dut_a (.i_clk(clk), .i_reset(rst), .bus(if_a.slave));
  pipe_stage_reg #(.NB_REG(32), .N_WORDS(2), .NB_CNT(2), .FLUSH_CYCLES(1))
    dut_b (.i_clk(clk), .i_reset(rst), .bus(if_b.slave));
  pipe_stage_reg #(.NB_REG(32), .N_WORDS(2), .NB_CNT(16), .FLUSH_CYCLES(4))
    dut_c (.i_clk(clk), .i_reset(rst), .bus(if_c.slave));

  assign if_a.i_dunit_clk_en = en;
  assign if_a.i_valid = valid;
  assign if_a.i_data = data;
  assign if_a.i_flush = flush;
  assign if_a.i_write = write;
  assign if_a.i_cnt_clear = clr;
  assign if_b.i_dunit_clk_en = en;
  assign if_b.i_valid = valid;
  assign if_b.i_data = data;
  assign if_b.i_flush = flush;
  assign if_b.i_write = write;
  assign if_b.i_cnt_clear = clr;
  assign if_c.i_dunit_clk_en = en;
  assign if_c.i_valid = valid;
  assign if_c.i_data = data;
  assign if_c.i_flush = flush;
  assign if_c.i_write = write;
  assign if_c.i_cnt_clear = clr;

  logic [63:0] d_data[3];
  logic        d_valid[3];
  logic        d_bubble[3];
  logic [15:0] d_stall[3];
  logic [15:0] d_flush[3];

  assign d_data[0] = if_a.o_data;
  assign d_data[1] = if_b.o_data;
  assign d_data[2] = if_c.o_data;
  assign d_valid[0] = if_a.o_valid;
  assign d_valid[1] = if_b.o_valid;
  assign d_valid[2] = if_c.o_valid;
  assign d_bubble[0] = if_a.o_bubble;
  assign d_bubble[1] = if_b.o_bubble;
  assign d_bubble[2] = if_c.o_bubble;
  assign d_stall[0] = if_a.o_stall_cnt;
  assign d_stall[1] = {14'd0, if_b.o_stall_cnt};
  assign d_stall[2] = if_c.o_stall_cnt;
  assign d_flush[0] = if_a.o_flush_cnt;
  assign d_flush[1] = {14'd0, if_b.o_flush_cnt};
  assign d_flush[2] = if_c.o_flush_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: per stage, how many enabled edges of forced-invalid output remain,
  // the visible payload, and counters as plain integers clipped at their ceiling.
  int          fc[3]   = '{3, 1, 4};
  int          cmax[3] = '{65535, 3, 65535};
  int          m_left[3];
  logic [63:0] m_data[3];
  logic        m_valid[3];
  int          m_stall[3];
  int          m_flush[3];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_left[k] = 0; m_data[k] = '0; m_valid[k] = 1'b0;
        m_stall[k] = 0; m_flush[k] = 0;
      end else if (en) begin
        if (clr) begin
          m_stall[k] = 0;
          m_flush[k] = 0;
        end else begin
          if (flush) m_flush[k] = (m_flush[k] + 1 > cmax[k]) ? cmax[k] : m_flush[k] + 1;
          if (!flush && m_left[k] == 0 && !write && m_valid[k])
            m_stall[k] = (m_stall[k] + 1 > cmax[k]) ? cmax[k] : m_stall[k] + 1;
        end
        if (flush) begin
          m_data[k] = '0; m_valid[k] = 1'b0; m_left[k] = fc[k] - 1;
        end else if (m_left[k] > 0) begin
          m_data[k] = '0; m_valid[k] = 1'b0; m_left[k] = m_left[k] - 1;
        end else if (write) begin
          m_data[k] = data; m_valid[k] = valid;
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("cyc_data_%0d", k), longint'(d_data[k]), longint'(m_data[k]));
      chk($sformatf("cyc_valid_%0d", k), longint'(d_valid[k]), longint'(m_valid[k]));
      chk($sformatf("cyc_bubble_%0d", k), longint'(d_bubble[k]), longint'(m_left[k] != 0));
      chk($sformatf("cyc_stall_%0d", k), longint'(d_stall[k]), longint'(m_stall[k]));
      chk($sformatf("cyc_flushcnt_%0d", k), longint'(d_flush[k]), longint'(m_flush[k]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {en, flush, write, valid, clr}
  logic [4:0] vec[12] = '{5'b10110, 5'b10000, 5'b10000, 5'b11100, 5'b10110, 5'b10111,
                          5'b00110, 5'b10100, 5'b11000, 5'b10000, 5'b10110, 5'b10001};

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; en = 1'b1; valid = 1'b0; data = '0;
    flush = 1'b0; write = 1'b0; clr = 1'b0;
    repeat (2) tick();
    chk("rst_valid_a", longint'(if_a.o_valid), 0);
    chk("rst_stall_a", longint'(if_a.o_stall_cnt), 0);
    rst = 1'b0;

    // Load, then reset between edges must clear at once.
    write = 1'b1; valid = 1'b1; data = {32'h11111111, 32'h22222222};
    tick();
    chk("pre_rst_data_a", longint'(if_a.o_data), 64'h1111111122222222);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_data_a", longint'(if_a.o_data), 0);
    chk("async_rst_valid_a", longint'(if_a.o_valid), 0);
    tick();
    rst = 1'b0;
    data = {32'hBBBBBBBB, 32'hAAAAAAAA};
    tick();
    chk("write_data_a", longint'(if_a.o_data), 64'hBBBBBBBBAAAAAAAA);
    chk("write_valid_a", longint'(if_a.o_valid), 1);

    // Stall three edges, then two more to saturate the 2-bit counter, then clear.
    write = 1'b0; data = {32'hDDDDDDDD, 32'hCCCCCCCC};
    repeat (3) tick();
    chk("stall_data_a", longint'(if_a.o_data), 64'hBBBBBBBBAAAAAAAA);
    chk("stall_cnt_a", longint'(if_a.o_stall_cnt), 3);
    repeat (2) tick();
    chk("stall_cnt_a5", longint'(if_a.o_stall_cnt), 5);
    chk("stall_sat_b", longint'(if_b.o_stall_cnt), 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_stall_a", longint'(if_a.o_stall_cnt), 0);
    chk("clr_stall_b", longint'(if_b.o_stall_cnt), 0);

    // Flush with three bubble edges on stage a.
    flush = 1'b1; write = 1'b1; valid = 1'b1;
    tick();
    chk("flush_valid_a", longint'(if_a.o_valid), 0);
    chk("flush_bubble_a", longint'(if_a.o_bubble), 1);
    chk("flush_cnt_a", longint'(if_a.o_flush_cnt), 1);
    flush = 1'b0; data = {32'h87654321, 32'h12345678};
    tick();
    chk("bub2_bubble_a", longint'(if_a.o_bubble), 1);
    chk("bub2_data_a", longint'(if_a.o_data), 0);
    tick();
    chk("bub3_bubble_a", longint'(if_a.o_bubble), 0);
    chk("bub3_valid_a", longint'(if_a.o_valid), 0);
    tick();
    chk("resume_data_a", longint'(if_a.o_data), 64'h8765432112345678);
    chk("resume_valid_a", longint'(if_a.o_valid), 1);

    // Debug freeze in the middle of a bubble run.
    flush = 1'b1;
    tick();
    en = 1'b0;
    repeat (5) tick();
    chk("freeze_bubble_a", longint'(if_a.o_bubble), 1);
    chk("freeze_flushcnt_a", longint'(if_a.o_flush_cnt), 2);
    chk("freeze_valid_a", longint'(if_a.o_valid), 0);
    en = 1'b1; flush = 1'b0; write = 1'b0;
    repeat (5) tick();

    // Reset pulse mid-bubble on stage c cancels the remaining bubbles.
    flush = 1'b1;
    tick();
    chk("midbub_bubble_c", longint'(if_c.o_bubble), 1);
    flush = 1'b0;
    rst = 1'b1;
    #1;
    chk("midbub_rst_bubble_c", longint'(if_c.o_bubble), 0);
    #1 rst = 1'b0;
    write = 1'b1; valid = 1'b1; data = {32'h0BADF00D, 32'hCAFEF00D};
    tick();
    chk("after_rst_data_c", longint'(if_c.o_data), 64'h0BADF00DCAFEF00D);
    chk("after_rst_valid_c", longint'(if_c.o_valid), 1);

    // Flush counter saturation on the narrow stage.
    flush = 1'b1;
    repeat (4) tick();
    flush = 1'b0;
    chk("flush_sat_b", longint'(if_b.o_flush_cnt), 3);
    chk("flush_cnt4_a", longint'(if_a.o_flush_cnt), 4);

    // Mixed directed vectors, checked by the per-cycle model.
    for (int i = 0; i < 12; i++) begin
      {en, flush, write, valid, clr} = vec[i];
      data = {32'(i) * 32'h01010101, ~(32'(i) * 32'h00100101)};
      tick();
    end
    en = 1'b1; flush = 1'b0; write = 1'b0; clr = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter NB_REG, default 32, width of one payload word.
REQ-002 Parameter N_WORDS, default 2, number of payload words per stage (e.g. PC+4, instruction).
REQ-003 Parameter NB_CNT, default 16, width of each performance counter.
REQ-004 Parameter FLUSH_CYCLES, default 1, range 1..15, number of bubble cycles inserted per flush.
REQ-005 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-006 i_reset  input  1  asynchronous, active-high reset.
REQ-007 i_dunit_clk_en  input  1  debug-unit clock enable; 0 freezes all state.
REQ-008 i_valid  input  1  upstream payload valid.
REQ-009 i_data  input  N_WORDS*NB_REG  upstream payload, word 0 in the LSBs.
REQ-010 i_flush  input  1  flush request; the held payload is discarded.
REQ-011 i_write  input  1  stage write enable; 0 means stall (hold).
REQ-012 i_cnt_clear  input  1  synchronous clear of both counters.
REQ-013 o_data  output  N_WORDS*NB_REG  registered payload.
REQ-014 o_valid  output  1  registered valid.
REQ-015 o_bubble  output  1  high while flush bubbles are still being inserted.
REQ-016 o_stall_cnt  output  NB_CNT  saturating count of stalled valid cycles.
REQ-017 o_flush_cnt  output  NB_CNT  saturating count of accepted flush requests.

Function
REQ-018 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-019 When i_dunit_clk_en=0, every register, including the counters and the bubble counter, SHALL hold its value.
REQ-020 An internal bubble counter bub_cnt (4 bits) SHALL drive o_bubble = (bub_cnt != 0).
REQ-021 When enabled, the SHALL priority per edge be: flush > bubble > write > hold.
REQ-022 Flush (i_flush=1): o_data <= 0, o_valid <= 0, bub_cnt <= FLUSH_CYCLES-1; this applies regardless of i_write and of the current bub_cnt (a re-flush reloads the counter).
REQ-023 Bubble (i_flush=0, bub_cnt!=0): o_data <= 0, o_valid <= 0, bub_cnt decrements; i_write and i_data are ignored.
REQ-024 Write (i_flush=0, bub_cnt=0, i_write=1): o_data <= i_data, o_valid <= i_valid; latency is one clock.
REQ-025 Hold (i_flush=0, bub_cnt=0, i_write=0): o_data and o_valid SHALL keep their values.
REQ-026 Flush latency: o_valid SHALL be 0 on the edge of the request plus FLUSH_CYCLES-1 further enabled edges; with FLUSH_CYCLES=1, writes resume on the next edge.
REQ-027 o_stall_cnt SHALL increment by 1 on each enabled hold edge where o_valid=1.
REQ-028 o_flush_cnt SHALL increment by 1 on each enabled edge with i_flush=1.
REQ-029 Counters SHALL saturate at 2^NB_CNT-1 and never wrap.
REQ-030 On an enabled edge, i_cnt_clear=1 SHALL set both counters to 0; clear overrides a same-edge increment, and payload behaviour is unaffected.
REQ-031 Each payload word SHALL be handled identically; there is no per-word enable.

Reset
REQ-032 While i_reset=1: o_data=0, o_valid=0, bub_cnt=0 (o_bubble=0), o_stall_cnt=0, o_flush_cnt=0, applied immediately and independent of i_clk and i_dunit_clk_en.
REQ-033 Reset asserted mid-bubble SHALL cancel the remaining bubbles; the first enabled edge after deassertion is a normal write/hold.

Verification
REQ-034 Reset: assert i_reset between edges -> all outputs 0 before the next edge; deassert, then i_write=1, i_valid=1, i_data={32'hBBBBBBBB,32'hAAAAAAAA} -> after one edge o_data matches, o_valid=1.
REQ-035 Stall: from the REQ-034 state, i_write=0, i_data={32'hDDDDDDDD,32'hCCCCCCCC} for 3 edges -> o_data unchanged, o_stall_cnt=3.
REQ-036 Flush with FLUSH_CYCLES=3: i_flush=1 for one edge with i_write=1 -> o_valid=0, o_data=0 for 3 edges, o_bubble=1 for the first 2; 4th edge loads i_data={32'h87654321,32'h12345678}; o_flush_cnt=1.
REQ-037 Debug freeze: i_dunit_clk_en=0 with i_write=1, i_flush=1 over 5 edges -> o_data, o_valid, both counters and o_bubble unchanged.
REQ-038 Counters: NB_CNT=2, stall 5 valid cycles -> o_stall_cnt=3 (saturated); i_cnt_clear=1 on a stall edge -> o_stall_cnt=0.
REQ-039 Reset mid-bubble: FLUSH_CYCLES=4, pulse i_reset after the flush edge -> o_bubble=0 immediately; the next write edge loads data with o_valid=i_valid.
